// File: rtl/poly_uniform_sampler_if.sv
// Handshake/bus bundle between the SHAKE128 stream core, the rejection
// sampler and the matrix-expansion store.
interface poly_uniform_sampler_if #(
    parameter int RATE_BYTES = 168,
    parameter int COEF_W     = 23,
    parameter int IDX_W      = 8
);
    logic                    start;
    logic                    busy;
    logic                    blk_req;
    logic                    blk_valid;
    logic [8*RATE_BYTES-1:0] blk_data;
    logic                    coef_valid;
    logic [IDX_W-1:0]        coef_idx;
    logic [COEF_W-1:0]       coef_data;
    logic                    done;
    logic                    err;
    logic [7:0]              nblocks;

    // master: drives start and the squeeze block; slave: the sampler
    modport master (
        output start, blk_valid, blk_data,
        input  busy, blk_req, coef_valid, coef_idx, coef_data, done, err, nblocks
    );
    modport slave (
        input  start, blk_valid, blk_data,
        output busy, blk_req, coef_valid, coef_idx, coef_data, done, err, nblocks
    );
endinterface

// File: rtl/poly_uniform_sampler.sv
// Rejection sampler: expands squeeze blocks into N coefficients < Q,
// streamed as (index, value). Leftover bytes at a block end are carried
// into the first candidate of the next block. Assumes RATE_BYTES >= CAND_BYTES.
module poly_uniform_sampler #(
    parameter int N          = 256,
    parameter int Q          = 8380417,
    parameter int CAND_BYTES = 3,
    parameter int COEF_W     = 23,
    parameter int RATE_BYTES = 168,
    parameter int MAX_BLOCKS = 16
) (
    input logic                   clock,
    input logic                   reset,
    poly_uniform_sampler_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int PW    = $clog2(RATE_BYTES + CAND_BYTES + 1);
    localparam int CW    = $clog2(CAND_BYTES + 1);
    localparam logic [COEF_W:0] Q_L = (COEF_W + 1)'(Q);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SCAN, FIN} state_t;
    state_t state, state_n;

    logic [8*RATE_BYTES-1:0]    blk_q;
    logic [PW-1:0]              ptr;
    logic [CAND_BYTES-1:0][7:0] carry;
    logic [CW-1:0]              carry_n;
    logic [CNT_W-1:0]           count;
    logic [7:0]                 nblk;
    logic                       fin_err;

    logic [CAND_BYTES-1:0][7:0] cand_bytes;
    logic [8*CAND_BYTES-1:0]    cand_flat;
    logic [COEF_W-1:0]          cand;
    logic                       accept, full, last_in_blk;
    logic [PW-1:0]              avail, rem_after, ptr_adv;
    logic [CNT_W-1:0]           count_inc;

    assign avail       = PW'(carry_n) + PW'(RATE_BYTES) - ptr;
    assign rem_after   = avail - PW'(CAND_BYTES);
    assign ptr_adv     = ptr + PW'(CAND_BYTES) - PW'(carry_n);
    assign last_in_blk = rem_after < PW'(CAND_BYTES);
    assign cand_flat   = cand_bytes;
    assign cand        = COEF_W'(cand_flat);
    assign accept      = {1'b0, cand} < Q_L;
    assign count_inc   = count + CNT_W'(accept);
    assign full        = count_inc == CNT_W'(N);
    assign bus.nblocks = nblk;

    // Candidate = carry bytes (oldest first) then block bytes from ptr, little-endian
    always_comb begin
        cand_bytes = '0;
        for (int i = 0; i < CAND_BYTES; i++) begin
            if (i < int'(carry_n))
                cand_bytes[i] = carry[i];
            else
                cand_bytes[i] = blk_q[8*(int'(ptr) + i - int'(carry_n)) +: 8];
        end
    end

    // Next-state: request, wait, scan one candidate per cycle, finish
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.start) state_n = REQ;
            REQ:  state_n = WAIT;
            WAIT: if (bus.blk_valid) state_n = SCAN;
            SCAN: begin
                if (full)
                    state_n = FIN;
                else if (last_in_blk)
                    state_n = (nblk == 8'(MAX_BLOCKS)) ? FIN : REQ;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            blk_q          <= '0;
            ptr            <= '0;
            carry          <= '0;
            carry_n        <= '0;
            count          <= '0;
            nblk           <= '0;
            fin_err        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.blk_req    <= 1'b0;
            bus.coef_valid <= 1'b0;
            bus.coef_idx   <= '0;
            bus.coef_data  <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state          <= state_n;
            bus.busy       <= state_n != IDLE;
            bus.blk_req    <= state_n == REQ;
            bus.coef_valid <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    count   <= '0;
                    carry_n <= '0;
                    nblk    <= '0;
                    fin_err <= 1'b0;
                end
                WAIT: if (bus.blk_valid) begin
                    blk_q <= bus.blk_data;
                    nblk  <= nblk + 8'd1;
                    ptr   <= '0;
                end
                SCAN: begin
                    ptr     <= ptr_adv;
                    carry_n <= '0;
                    if (accept) begin
                        bus.coef_valid <= 1'b1;
                        bus.coef_idx   <= IDX_W'(count);
                        bus.coef_data  <= cand;
                        count          <= count_inc;
                    end
                    // Block tail shorter than a candidate moves to carry
                    if (!full && last_in_blk) begin
                        carry_n <= CW'(rem_after);
                        for (int j = 0; j < CAND_BYTES; j++)
                            if (j < int'(rem_after))
                                carry[j] <= blk_q[8*(RATE_BYTES - int'(rem_after) + j) +: 8];
                        if (nblk == 8'(MAX_BLOCKS)) fin_err <= 1'b1;
                    end
                end
                FIN: begin
                    bus.done <= !fin_err;
                    bus.err  <= fin_err;
                end
                default: ;
            endcase
        end
    end
endmodule
